// File: rtl/oled_scene_controller_if.sv
// Scene controller bundle: control levels/strobes and pixel hit flags in,
// mode/animation/shape state and the composited pixel colour out.
interface oled_scene_controller_if;
    logic        enable;
    logic        start;
    logic        next_pulse;
    logic        step_tick;
    logic        hit_outer;
    logic        hit_inner;
    logic        hit_anim;
    logic        hit_square;
    logic        hit_circle;
    logic        hit_tri;
    logic [1:0]  mode;
    logic [3:0]  anim_state;
    logic [1:0]  shape_sel;
    logic [15:0] oled_data;

    modport master (
        output enable, start, next_pulse, step_tick,
        output hit_outer, hit_inner, hit_anim, hit_square, hit_circle, hit_tri,
        input  mode, anim_state, shape_sel, oled_data
    );

    modport slave (
        input  enable, start, next_pulse, step_tick,
        input  hit_outer, hit_inner, hit_anim, hit_square, hit_circle, hit_tri,
        output mode, anim_state, shape_sel, oled_data
    );
endinterface

// File: rtl/oled_scene_controller.sv
// OLED scene mode FSM, border-animation/shape sequencing and priority pixel compositor; OLED_SCENE_AUTOCYCLE_EN adds automatic shape advance.
// Latency: mode/anim_state/shape_sel update on the triggering edge; oled_data is one registered cycle behind the hit flags.
// Backpressure: none; strobes are single-cycle and always consumed, the pixel stream is free-running.
module oled_scene_controller #(
    parameter int          ANIM_STEPS = 9,
    parameter int          AUTO_TICKS = 4,
    parameter logic [15:0] COL_OUTER  = 16'hF800,
    parameter logic [15:0] COL_INNER  = 16'hFD20,
    parameter logic [15:0] COL_ANIM   = 16'h07E0,
    parameter logic [15:0] COL_SQUARE = 16'hF800,
    parameter logic [15:0] COL_CIRCLE = 16'hFD20,
    parameter logic [15:0] COL_TRI    = 16'h07E0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    oled_scene_controller_if.slave    bus
);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_IDLE   = 2'd1,
        MODE_ACTIVE = 2'd2
    } mode_e;

    localparam logic [3:0] ANIM_LAST = 4'(ANIM_STEPS - 1);

    if (ANIM_STEPS < 2 || ANIM_STEPS > 16) begin : g_bad_anim_steps
        $error("ANIM_STEPS must be in 2..16");
    end
    if (AUTO_TICKS < 1 || AUTO_TICKS > 15) begin : g_bad_auto_ticks
        $error("AUTO_TICKS must be in 1..15");
    end

    mode_e       state_q, state_d;
    logic [3:0]  anim_q, anim_d;
    logic [1:0]  shape_q, shape_d;
    logic [1:0]  shape_nxt;
    logic [15:0] pix_q, pix_d;
    logic        is_active;
    logic        auto_adv;
    logic        shape_hit;

    assign is_active = (state_q == MODE_ACTIVE);
    assign shape_nxt = (shape_q == 2'd3) ? 2'd1 : shape_q + 2'd1;

`ifdef OLED_SCENE_AUTOCYCLE_EN
    logic [3:0] tick_q, tick_d;

    // A manual next_pulse wins and restarts the count, so a coincident auto event never double-steps.
    always_comb begin
        tick_d   = tick_q;
        auto_adv = 1'b0;
        if (!bus.enable) begin
            tick_d = '0;
        end else if (is_active) begin
            if (bus.next_pulse) begin
                tick_d = '0;
            end else if (bus.step_tick && anim_q == ANIM_LAST) begin
                if (tick_q == 4'(AUTO_TICKS - 1)) begin
                    tick_d   = '0;
                    auto_adv = 1'b1;
                end else begin
                    tick_d = tick_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tick_q <= '0;
        else        tick_q <= tick_d;
    end
`else
    assign auto_adv = 1'b0;
`endif

    // Strobes only count when already ACTIVE before the edge; enable low overrides everything.
    always_comb begin
        state_d = state_q;
        anim_d  = anim_q;
        shape_d = shape_q;
        if (!bus.enable) begin
            state_d = MODE_OFF;
            anim_d  = '0;
            shape_d = '0;
        end else begin
            case (state_q)
                MODE_OFF:    state_d = MODE_IDLE;
                MODE_IDLE:   if (bus.start) state_d = MODE_ACTIVE;
                MODE_ACTIVE: state_d = MODE_ACTIVE;
                default:     state_d = MODE_OFF;
            endcase
            if (is_active) begin
                if (bus.step_tick && anim_q != ANIM_LAST) anim_d = anim_q + 4'd1;
                if (bus.next_pulse || auto_adv)          shape_d = shape_nxt;
            end
        end
    end

    always_comb begin
        shape_hit = 1'b0;
        case (shape_q)
            2'd1:    shape_hit = bus.hit_square;
            2'd2:    shape_hit = bus.hit_circle;
            2'd3:    shape_hit = bus.hit_tri;
            default: shape_hit = 1'b0;
        endcase
    end

    always_comb begin
        pix_d = 16'h0000;
        if (bus.hit_outer && state_q != MODE_OFF)  pix_d = COL_OUTER;
        else if (bus.hit_inner && is_active)       pix_d = COL_INNER;
        else if (bus.hit_anim && is_active)        pix_d = COL_ANIM;
        else if (shape_hit && is_active) begin
            case (shape_q)
                2'd1:    pix_d = COL_SQUARE;
                2'd2:    pix_d = COL_CIRCLE;
                default: pix_d = COL_TRI;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MODE_OFF;
            anim_q  <= '0;
            shape_q <= '0;
            pix_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            anim_q  <= anim_d;
            shape_q <= shape_d;
            pix_q   <= pix_d;
        end
    end

    assign bus.mode       = state_q;
    assign bus.anim_state = anim_q;
    assign bus.shape_sel  = shape_q;
    assign bus.oled_data  = pix_q;

endmodule

// File: tb/tb_oled_scene_controller.sv
// Directed bench for oled_scene_controller: expected pixels queued per driven cycle, popped after the edge.
module tb_oled_scene_controller;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #20 clk = ~clk;

    oled_scene_controller_if bus();

    oled_scene_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];

`ifdef OLED_SCENE_AUTOCYCLE_EN
    localparam int N_TICKS = 11;
    localparam bit AUTO    = 1'b1;
`else
    localparam int N_TICKS = 12;
    localparam bit AUTO    = 1'b0;
`endif

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Queue the pixel expected from the hits driven now, clock once, then compare.
    task automatic cyc(input logic [15:0] expected_pix);
        logic [15:0] e;
        exp_q.push_back(expected_pix);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("oled_data", bus.oled_data, e);
    endtask

    task automatic set_hits(input logic o, input logic i, input logic a,
                            input logic s, input logic c, input logic t);
        bus.hit_outer  = o;
        bus.hit_inner  = i;
        bus.hit_anim   = a;
        bus.hit_square = s;
        bus.hit_circle = c;
        bus.hit_tri    = t;
    endtask

    initial begin
        logic [1:0]  shape_tbl [5];
        logic [15:0] pix_tbl   [5];
        shape_tbl = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
        pix_tbl   = '{16'h0000, 16'h0000, 16'hFD20, 16'h0000, 16'h0000};

        bus.enable = 1'b0; bus.start = 1'b0; bus.next_pulse = 1'b0; bus.step_tick = 1'b0;
        set_hits(0, 0, 0, 0, 0, 0);

        #10;
        chk("reset_mode",  16'(bus.mode),       16'd0);
        chk("reset_anim",  16'(bus.anim_state), 16'd0);
        chk("reset_shape", 16'(bus.shape_sel),  16'd0);
        chk("reset_pix",   bus.oled_data,       16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // OFF -> IDLE, outer border only shows once mode has left OFF
        bus.enable = 1'b1;
        set_hits(1, 0, 0, 0, 0, 0);
        cyc(16'h0000);
        chk("idle_mode", 16'(bus.mode), 16'd1);
        cyc(16'hF800);
        set_hits(0, 1, 0, 0, 0, 0);
        cyc(16'h0000);

        // IDLE -> ACTIVE; strobes in the transition cycle are ignored
        bus.start = 1'b1; bus.step_tick = 1'b1; bus.next_pulse = 1'b1;
        cyc(16'h0000);
        chk("active_mode",      16'(bus.mode),       16'd2);
        chk("trans_anim_ign",   16'(bus.anim_state), 16'd0);
        chk("trans_shape_ign",  16'(bus.shape_sel),  16'd0);
        bus.start = 1'b0; bus.step_tick = 1'b0; bus.next_pulse = 1'b0;
        set_hits(0, 1, 1, 0, 0, 0);
        cyc(16'hFD20);

        // animation counts up and saturates at ANIM_STEPS-1
        bus.step_tick = 1'b1;
        for (int i = 1; i <= N_TICKS; i++) begin
            cyc(16'hFD20);
            chk("anim_step", 16'(bus.anim_state), 16'((i < 8) ? i : 8));
        end
        bus.step_tick = 1'b0;
        chk("anim_shape_hold", 16'(bus.shape_sel), 16'd0);

        // shape sequence with circle hit
        set_hits(0, 0, 0, 0, 1, 0);
        cyc(16'h0000);
        bus.next_pulse = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(pix_tbl[i]);
            chk("shape_seq", 16'(bus.shape_sel), 16'(shape_tbl[i]));
        end
        bus.next_pulse = 1'b0;
        cyc(16'hFD20);

        // enable falls together with both strobes
        bus.enable = 1'b0; bus.next_pulse = 1'b1; bus.step_tick = 1'b1;
        set_hits(1, 1, 1, 1, 1, 1);
        cyc(16'hF800);
        chk("off_mode",  16'(bus.mode),       16'd0);
        chk("off_shape", 16'(bus.shape_sel),  16'd0);
        chk("off_anim",  16'(bus.anim_state), 16'd0);
        bus.next_pulse = 1'b0; bus.step_tick = 1'b0;
        cyc(16'h0000);

        // back to ACTIVE, then asynchronous reset between edges
        bus.enable = 1'b1;
        set_hits(0, 0, 0, 0, 0, 0);
        cyc(16'h0000);
        bus.start = 1'b1;
        cyc(16'h0000);
        bus.start = 1'b0; bus.step_tick = 1'b1; bus.next_pulse = 1'b1;
        cyc(16'h0000);
        chk("re_anim",  16'(bus.anim_state), 16'd1);
        chk("re_shape", 16'(bus.shape_sel),  16'd1);
        bus.step_tick = 1'b0; bus.next_pulse = 1'b0;
        set_hits(0, 0, 0, 1, 0, 0);
        cyc(16'hF800);
        #5 rst_n = 1'b0;
        #1;
        chk("arst_mode",  16'(bus.mode),       16'd0);
        chk("arst_anim",  16'(bus.anim_state), 16'd0);
        chk("arst_shape", 16'(bus.shape_sel),  16'd0);
        chk("arst_pix",   bus.oled_data,       16'h0000);
        #5 rst_n = 1'b1;
        cyc(16'h0000);
        chk("post_rst_mode", 16'(bus.mode), 16'd1);
        set_hits(1, 0, 0, 0, 0, 0);
        cyc(16'hF800);

        // saturated animation, further ticks: auto advance only when enabled
        set_hits(0, 0, 0, 0, 0, 0);
        bus.start = 1'b1;
        cyc(16'h0000);
        bus.start = 1'b0; bus.step_tick = 1'b1;
        for (int i = 0; i < 8; i++) cyc(16'h0000);
        chk("sat_anim", 16'(bus.anim_state), 16'd8);
        for (int i = 1; i <= 8; i++) begin
            cyc(16'h0000);
            chk("auto_shape", 16'(bus.shape_sel),
                16'(AUTO ? ((i >= 8) ? 2 : (i >= 4) ? 1 : 0) : 0));
        end
        bus.step_tick = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/oled_scene_controller.md
# oled_scene_controller

Sequencing and compositing controller for the 96x64 OLED scene. It owns the display mode FSM (off / outer border / active scene), the border-animation step counter, and the shape-selection sequence. It priority-composites the per-pixel hit flags from the shape and border drawing units into one registered `oled_data` word for the OLED driver. It sits between the debounced button/switch logic and the `Oled_Display` pixel_data input.

## Interface
Parameters:
- `ANIM_STEPS`, 9: number of border-animation steps; the counter runs 0..ANIM_STEPS-1, range 2..16.
- `AUTO_TICKS`, 4: `step_tick` count between automatic shape advances. Used only with `OLED_SCENE_AUTOCYCLE_EN`. Range 1..15.
- `COL_OUTER`, 16'hF800: outer border colour.
- `COL_INNER`, 16'hFD20: inner border colour.
- `COL_ANIM`, 16'h07E0: animation colour.
- `COL_SQUARE` / `COL_CIRCLE` / `COL_TRI`, 16'hF800 / 16'hFD20 / 16'h07E0: shape colours.

Ports:
- `clk`  in  1  pixel-domain clock (25 MHz)
- `rst_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  scene enable level (switch), synchronous to `clk`
- `start`  in  1  start level (centre button), synchronous
- `next_pulse`  in  1  single-cycle debounced "next shape" strobe
- `step_tick`  in  1  single-cycle 2 Hz animation strobe
- `hit_outer`, `hit_inner`, `hit_anim`  in  1 each  border/animation hit for the current pixel_index
- `hit_square`, `hit_circle`, `hit_tri`  in  1 each  shape hit for the current pixel_index
- `mode`  out  2  FSM state: 0=OFF, 1=IDLE, 2=ACTIVE
- `anim_state`  out  4  animation step, drives the animation generator
- `shape_sel`  out  2  0=none, 1=square, 2=circle, 3=triangle
- `oled_data`  out  16  composited pixel colour

## Operation
- OFF: entered when `enable` is 0. `anim_state` and `shape_sel` are forced to 0 every cycle.
- OFF -> IDLE when `enable` is 1.
- IDLE -> ACTIVE when `enable` is 1 and `start` is 1.
- ACTIVE holds until `enable` is 0. There is no other exit, so `start` is sticky.
- Any state -> OFF when `enable` is 0. This has priority over all other events in the same cycle.
- `anim_state`: increments on `step_tick` only while `mode` is ACTIVE. It saturates at ANIM_STEPS-1 and stays 0 outside ACTIVE.
- `shape_sel`: on `next_pulse` while ACTIVE, steps 0->1->2->3->1. It never returns to 0 except via OFF or reset.
- Strobes (`next_pulse`, `step_tick`) arriving in the cycle of the IDLE->ACTIVE transition are ignored. They count only when `mode` is already ACTIVE at the clock edge.
- Compositing priority, highest first:
  1. `hit_outer` with mode != OFF -> COL_OUTER
  2. `hit_inner` with ACTIVE -> COL_INNER
  3. `hit_anim` with ACTIVE -> COL_ANIM
  4. hit of the selected shape (by current `shape_sel`) -> its colour
  5. otherwise 16'h0000
- With `shape_sel` at 0, no shape is drawn. Outside ACTIVE, shapes are never drawn.

## Timing
- Reset (`rst_n` low, asynchronous): `mode`=0, `anim_state`=0, `shape_sel`=0, `oled_data`=16'h0000. These hold until the first `clk` edge after deassertion.
- `mode`, `anim_state` and `shape_sel` update on the same edge as the triggering input. There are no combinational paths from inputs to outputs.
- `oled_data` has 1-cycle latency. The hit flags sampled at edge N determine `oled_data` after edge N, using `mode`/`shape_sel` as registered before edge N.
- `enable` falling: `mode` reads 0 after the next edge. `oled_data` goes black one edge later, for any pixel without a higher-priority hit; with mode OFF, every pixel is black.
- Reset mid-scene aborts immediately. Counters restart from 0.

## Configuration
- `OLED_SCENE_AUTOCYCLE_EN` defined:
  - While ACTIVE and `anim_state` is ANIM_STEPS-1, an internal 4-bit tick counter counts `step_tick`s.
  - On reaching AUTO_TICKS, the counter advances `shape_sel` as `next_pulse` would and restarts at 0.
  - A manual `next_pulse` also clears the counter.
  - If both events coincide, `shape_sel` advances once.
  - The counter clears on OFF and on reset.
- Undefined: there is no auto counter. `shape_sel` changes only on `next_pulse`, and AUTO_TICKS is unused.

## Test plan
- Reset, then `enable`=1 for 2 cycles with `hit_outer`=1 -> `mode`=1; `oled_data`=F800 two edges after `enable` rises; with `hit_inner`=1 only, `oled_data`=0000.
- `start`=1 for 1 cycle in IDLE, then 12 `step_tick`s -> `mode`=2; `anim_state` counts 1..8 and holds at 8; `hit_inner`&`hit_anim` -> FD20.
- In ACTIVE, 4 `next_pulse`s with `hit_circle`=1 -> `shape_sel` goes 1,2,3,1; `oled_data`=FD20 only while `shape_sel`=2, else 0000.
- `enable` falls in the same cycle as `next_pulse` and `step_tick` -> `mode`=0, `shape_sel`=0, `anim_state`=0; all hits -> 0000 one edge later.
- `rst_n` pulsed low mid-ACTIVE between edges -> outputs clear immediately without waiting for a `clk` edge; scene re-enters IDLE after release.
- With `OLED_SCENE_AUTOCYCLE_EN`: ACTIVE with animation saturated, 8 `step_tick`s -> `shape_sel` advances 0->1->2 (after ticks 4 and 8).
